caesar_decoder: RTL and testbench

CAESAR_DECODER -- requirements
Module: caesar_decoder

---
 rtl/caesar_decoder_pkg.sv | 34 +++
 rtl/caesar_decoder_if.sv | 26 ++
 rtl/caesar_decoder_sym_fifo.sv | 64 ++++++
 rtl/caesar_decoder.sv | 79 +++++++
 tb/tb_caesar_decoder.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/caesar_decoder_pkg.sv
// Shared definitions for the Caesar encoder/decoder pair.
// Holds the code and digit widths, the legal digit range, the marker
// digit for illegal codes, the buffered symbol layout, and the decode helper.
package caesar_decoder_pkg;

    localparam int unsigned CODE_W    = 5;
    localparam int unsigned DIGIT_W   = 4;
    localparam int unsigned DIGIT_MAX = 9;
    localparam logic [DIGIT_W-1:0] ERR_DIGIT = 4'hF;

    // One buffered entry: {err, digit}
    typedef struct packed {
        logic               err;
        logic [DIGIT_W-1:0] digit;
    } sym_t;

    // A code in shift..shift+DIGIT_MAX maps to code-shift; anything else is
    // reported as an error with the marker digit.
    function automatic sym_t decode_code(input logic [CODE_W-1:0] code,
                                         input int unsigned       shift);
        sym_t        s;
        int unsigned c;
        c = 32'(code);
        if (c >= shift && c <= shift + DIGIT_MAX) begin
            s.err   = 1'b0;
            s.digit = DIGIT_W'(c - shift);
        end else begin
            s.err   = 1'b1;
            s.digit = ERR_DIGIT;
        end
        return s;
    endfunction

endpackage

// File: rtl/caesar_decoder_if.sv
// Handshake bundle around the Caesar decoder.
//   in_valid/in_code/in_accept : upstream code push
//   out_valid/out_digit/out_err/out_take : head entry and consumer pop
// master = the environment (producer + consumer), slave = the decoder.
interface caesar_decoder_if;
    import caesar_decoder_pkg::*;

    logic               in_valid;
    logic [CODE_W-1:0]  in_code;
    logic               in_accept;
    logic               out_valid;
    logic [DIGIT_W-1:0] out_digit;
    logic               out_err;
    logic               out_take;

    modport master (
        output in_valid, in_code, out_take,
        input  in_accept, out_valid, out_digit, out_err
    );

    modport slave (
        input  in_valid, in_code, out_take,
        output in_accept, out_valid, out_digit, out_err
    );

endinterface

// File: rtl/caesar_decoder_sym_fifo.sv
// caesar_sym_fifo: DEPTH-entry buffer of decoded symbols.
//   clk_i/rst_i : clock, synchronous active-high reset
//   push_i/data_i : write an entry (caller guarantees room or a same-edge pop)
//   pop_i/data_o  : remove the head entry (caller guarantees non-empty)
//   empty_o/full_o : occupancy status
// Pointers wrap naturally because DEPTH is a power of two.
module caesar_sym_fifo
    import caesar_decoder_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  sym_t data_i,
    input  logic pop_i,
    output sym_t data_o,
    output logic empty_o,
    output logic full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    sym_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/caesar_decoder.sv
// caesar_decoder: removes a Caesar offset from incoming 5-bit codes and
// buffers the resulting {err, digit} entries for a downstream consumer.
//   ready     : clock (rising edge)       reset     : sync, active-high
//   in_valid/in_code/in_accept            : code push handshake
//   out_valid/out_digit/out_err/out_take  : head entry and pop
//   err_count : saturating count of accepted illegal codes
//   ovf       : sticky, a code was dropped because the buffer was full
module caesar_decoder
    import caesar_decoder_pkg::*;
#(
    parameter int unsigned SHIFT = 3,
    parameter int unsigned DEPTH = 4
) (
    input  logic               ready,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [CODE_W-1:0]  in_code,
    output logic               in_accept,
    output logic               out_valid,
    output logic [DIGIT_W-1:0] out_digit,
    output logic               out_err,
    input  logic               out_take,
    output logic [7:0]         err_count,
    output logic               ovf
);

    logic full, empty, push, pop, drop;
    sym_t sym_in, sym_head;

    logic [7:0] err_count_q, err_count_d;
    logic       ovf_q,       ovf_d;

    assign sym_in = decode_code(in_code, SHIFT);

    // A full buffer that is popped on the same edge still takes the offered
    // code, so occupancy holds and nothing is lost. in_accept itself depends
    // only on occupancy, keeping out_take off any combinational output path.
    assign pop  = !empty && out_take;
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && full && !pop;

    always_comb begin
        err_count_d = err_count_q;
        ovf_d       = ovf_q | drop;
        if (push && sym_in.err && err_count_q != 8'hFF)
            err_count_d = err_count_q + 8'd1;
    end

    always_ff @(posedge ready) begin
        if (reset) begin
            err_count_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            err_count_q <= err_count_d;
            ovf_q       <= ovf_d;
        end
    end

    caesar_sym_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (ready),
        .rst_i   (reset),
        .push_i  (push),
        .data_i  (sym_in),
        .pop_i   (pop),
        .data_o  (sym_head),
        .empty_o (empty),
        .full_o  (full)
    );

    assign in_accept = !full;
    assign out_valid = !empty;
    assign out_digit = empty ? '0 : sym_head.digit;
    assign out_err   = !empty && sym_head.err;
    assign err_count = err_count_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_caesar_decoder.sv
module tb_caesar_decoder;
    import caesar_decoder_pkg::*;

    logic       ready = 1'b0;
    logic       reset;
    logic [7:0] err_count;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    caesar_decoder_if bus ();

    always #5 ready = ~ready;

    caesar_decoder #(
        .SHIFT (3),
        .DEPTH (4)
    ) dut (
        .ready     (ready),
        .reset     (reset),
        .in_valid  (bus.in_valid),
        .in_code   (bus.in_code),
        .in_accept (bus.in_accept),
        .out_valid (bus.out_valid),
        .out_digit (bus.out_digit),
        .out_err   (bus.out_err),
        .out_take  (bus.out_take),
        .err_count (err_count),
        .ovf       (ovf)
    );

    task automatic tick();
        @(posedge ready);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_code  = '0;
        bus.out_take = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_digit", 32'(bus.out_digit), 0);
        chk("rst_out_err",   32'(bus.out_err),   0);
        chk("rst_in_accept", 32'(bus.in_accept), 1);
        chk("rst_err_count", 32'(err_count),     0);
        chk("rst_ovf",       32'(ovf),           0);
        reset = 1'b0;

        // Legal codes 3..12 stream through as digits 0..9
        bus.out_take = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_code  = 5'(3 + i);
            tick();
            chk("legal_valid", 32'(bus.out_valid), 1);
            chk("legal_digit", 32'(bus.out_digit), 32'(i));
            chk("legal_err",   32'(bus.out_err),   0);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("legal_drain_valid", 32'(bus.out_valid), 0);
        chk("legal_drain_digit", 32'(bus.out_digit), 0);
        chk("legal_err_count",   32'(err_count),     0);

        // Illegal codes just below, just above, and at the top of the range
        begin
            logic [4:0] bad [3];
            bad[0] = 5'd2; bad[1] = 5'd13; bad[2] = 5'd31;
            for (int i = 0; i < 3; i++) begin
                bus.in_valid = 1'b1;
                bus.in_code  = bad[i];
                tick();
                chk("illegal_valid", 32'(bus.out_valid), 1);
                chk("illegal_digit", 32'(bus.out_digit), 32'hF);
                chk("illegal_err",   32'(bus.out_err),   1);
            end
        end
        bus.in_valid = 1'b0;
        tick();
        chk("illegal_err_count", 32'(err_count),     3);
        chk("illegal_drained",   32'(bus.out_valid), 0);

        // Fill without popping, then overflow with a fifth code
        bus.out_take = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            bus.in_valid = 1'b1;
            bus.in_code  = 5'(3 + k);
            tick();
            chk("fill_in_accept", 32'(bus.in_accept), (k < 4) ? 1 : 0);
        end
        bus.in_code = 5'd8;
        tick();
        chk("ovf_set",       32'(ovf),           1);
        chk("ovf_in_accept", 32'(bus.in_accept), 0);
        chk("ovf_hold_digit", 32'(bus.out_digit), 1);
        bus.in_valid = 1'b0;
        tick();
        chk("ovf_hold_digit2", 32'(bus.out_digit), 1);
        chk("ovf_sticky",      32'(ovf),           1);
        bus.out_take = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("ovf_pop_valid", 32'(bus.out_valid), 1);
            chk("ovf_pop_digit", 32'(bus.out_digit), 32'(j + 1));
            tick();
        end
        chk("ovf_fifth_dropped", 32'(bus.out_valid), 0);
        bus.out_take = 1'b0;

        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("ovf_cleared", 32'(ovf), 0);
        chk("cnt_cleared", 32'(err_count), 0);

        // Full buffer with simultaneous push and pop
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.in_code  = 5'(3 + k);
            tick();
        end
        chk("full_in_accept", 32'(bus.in_accept), 0);
        bus.in_code  = 5'd7;
        bus.out_take = 1'b1;
        tick();
        chk("pp_in_accept", 32'(bus.in_accept), 0);
        chk("pp_ovf",       32'(ovf),           0);
        chk("pp_head",      32'(bus.out_digit), 1);
        bus.in_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk("pp_pop_digit", 32'(bus.out_digit), 32'(j + 1));
            tick();
        end
        chk("pp_empty", 32'(bus.out_valid), 0);

        // 260 illegal codes saturate the error counter
        bus.in_valid = 1'b1;
        bus.in_code  = 5'd0;
        for (int n = 0; n < 254; n++) tick();
        chk("sat_254", 32'(err_count), 254);
        for (int n = 0; n < 6; n++) tick();
        bus.in_valid = 1'b0;
        tick();
        chk("sat_255",   32'(err_count),     255);
        chk("sat_empty", 32'(bus.out_valid), 0);

        // Reset with three entries held and a push pending
        bus.out_take = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.in_code  = 5'(3 + k);
            tick();
        end
        chk("pre_rst_valid",  32'(bus.out_valid), 1);
        chk("pre_rst_accept", 32'(bus.in_accept), 1);
        bus.in_code = 5'd6;
        reset       = 1'b1;
        tick();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        chk("rst2_out_valid", 32'(bus.out_valid), 0);
        chk("rst2_out_digit", 32'(bus.out_digit), 0);
        chk("rst2_err_count", 32'(err_count),     0);
        chk("rst2_ovf",       32'(ovf),           0);
        chk("rst2_in_accept", 32'(bus.in_accept), 1);
        tick();
        chk("rst2_push_discarded", 32'(bus.out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
